fifo_sync_flags: RTL and testbench
==================================

# fifo_sync_flags

Parametrised single-clock FIFO, the successor to the basic full/empty synchronous FIFO. It adds programmable almost-full and almost-empty thresholds, an occupancy count, and overflow/underflow error pulses. A mode parameter selects registered-read or first-word-fall-through output. It sits between a producer and a consumer in the same clock domain, as the standard buffering element for streaming datapaths.

## Interface
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 8: number of storage entries, ≥2; need not be a power of two.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 selects registered read; 1 selects first-word-fall-through.
- CW, $clog2(DEPTH+1): count width (derived, not to be overridden).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- r_en  in  1  read request.
- in_data  in  WIDTH  write data, sampled on an accepted write.
- out_data  out  WIDTH  read data (see Operation).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

## Operation
- State: storage of DEPTH×WIDTH, wr_ptr and rd_ptr (each 0..DEPTH-1, wrapping from DEPTH-1 to 0), and a count register.
- Read accepted (rd_acc) = r_en && !empty.
- Write accepted (wr_acc) = w_en && (!full || rd_acc). A write to a full FIFO succeeds only when a read is accepted in the same cycle.
- No empty bypass: with empty=1, a simultaneous read is rejected even if w_en=1. The write is still accepted.
- wr_acc: mem[wr_ptr] ← in_data; wr_ptr advances.
- rd_acc: rd_ptr advances.
- Count: +1 on a write alone, −1 on a read alone, unchanged on both or neither.
- full, empty, almost_full and almost_empty are decoded combinationally from the count register only.
- FWFT=0: out_data is a register loaded with mem[rd_ptr] on rd_acc and held otherwise.
- FWFT=1: out_data = mem[rd_ptr] continuously. It is valid whenever empty=0; when empty=1 its value is don't-care. rd_acc pops the head.
- overflow is registered: 1 in the cycle after w_en && !wr_acc, otherwise 0.
- underflow is registered: 1 in the cycle after r_en && !rd_acc, otherwise 0.
- A rejected operation changes no pointer, count or storage.

## Timing
- Reset (rst=1 at an edge) values: wr_ptr=0, rd_ptr=0, count=0, out_data=0 (FWFT=0), overflow=0, underflow=0.
- Resulting flags: empty=1, full=0, almost_empty=1 (since AE_LEVEL ≥ 0), almost_full=0.
- Storage contents are not cleared.
- rst has priority over w_en and r_en in the same cycle. A reset mid-stream discards all contents, and no pulse is generated for requests made that cycle.
- Write-to-visible latency: a word written at edge N raises count and clears empty after edge N. With FWFT=1 it also appears on out_data after edge N.
- FWFT=0 read latency: r_en accepted at edge N, so out_data holds the word after edge N (one cycle).
- Flags update on the same edge as count; there is no extra pipeline stage.
- Sustained full rate: one write and one read per cycle with no bubbles at any occupancy from 1 to DEPTH.

## Test plan
- Reset, then fill (WIDTH=8, DEPTH=8, FWFT=0): 8 writes of 0x11..0x88 → count steps 1..8. almost_full rises when count reaches 7 and full at 8. empty falls after the first write. almost_empty falls when count reaches 2.
- Overflow: with the FIFO full, w_en=1, r_en=0, in_data=0x99 → overflow=1 for exactly one cycle, count stays 8, and 0x99 is never read. Then drain 8 reads → out_data 0x11..0x88 in order, one cycle after each r_en. Then r_en=1 on empty → underflow pulse, out_data holds 0x88.
- Simultaneous read and write when full: w_en=r_en=1 with data 0xA5 → count stays 8, head popped, 0xA5 read out last.
- Simultaneous read and write when empty: w_en=r_en=1 with data 0x3C → underflow pulse, count becomes 1, next read returns 0x3C.
- Wrap-around with DEPTH=5: run 12 interleaved write/read pairs → data order preserved across pointer wrap and count never exceeds 5. With FWFT=1, out_data shows each head on the cycle after it is written, with no r_en needed.
- Reset mid-operation: with count=4, assert rst together with w_en=1 → count=0, empty=1, no overflow pulse, and the old data never appears.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and selectable registered or FWFT output.
module fifo_sync_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic             r_en,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int            PW         = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] COUNT_AE   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, underflow_reg;
    logic          rd_acc, wr_acc;

    // Flags come straight from the count register so they move on the same edge.
    assign full         = (count_reg == COUNT_FULL);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= COUNT_AF);
    assign almost_empty = (count_reg <= COUNT_AE);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    always_comb begin
        rd_acc      = r_en && !empty;
        wr_acc      = w_en && (!full || rd_acc);
        wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
        rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
        count_next  = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_next;
            if (rd_acc) rd_ptr_reg <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= w_en && !wr_acc;
            underflow_reg <= r_en && !rd_acc;
        end
    end

    // Storage is never cleared; reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign out_data = mem[rd_ptr_reg];
        end else begin : g_registered
            logic [WIDTH-1:0] out_data_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_data_reg <= '0;
                end else if (rd_acc) begin
                    out_data_reg <= mem[rd_ptr_reg];
                end
            end
            assign out_data = out_data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Drives a registered-read DEPTH=8 FIFO and an FWFT DEPTH=5 FIFO with the same
// stimulus and compares both against queue-based reference models.
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst, w_en, r_en;
    logic [7:0] in_data;

    logic [7:0] a_out;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [3:0] a_count;

    logic [7:0] b_out;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_count;

    int checks = 0;
    int errors = 0;

    // Reference state: contents as queues, plus the expected registered outputs.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] a_out_exp;
    logic       a_ovf_exp, a_unf_exp, b_ovf_exp, b_unf_exp;

    always #5 clk = ~clk;

    fifo_sync_flags #(.WIDTH(8), .DEPTH(8), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .in_data(in_data),
        .out_data(a_out), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_sync_flags #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(5), .AE_LEVEL(0), .FWFT(1)) dut_b (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .in_data(in_data),
        .out_data(b_out), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
        logic rd, wr;
        w_en = w; r_en = r; in_data = d; rst = rs;
        @(posedge clk);
        if (rs) begin
            qa.delete(); qb.delete();
            a_out_exp = 8'h00;
            a_ovf_exp = 1'b0; a_unf_exp = 1'b0; b_ovf_exp = 1'b0; b_unf_exp = 1'b0;
        end else begin
            rd = r && (qa.size() != 0);
            wr = w && (qa.size() != 8 || rd);
            if (rd) a_out_exp = qa.pop_front();
            if (wr) qa.push_back(d);
            a_ovf_exp = w && !wr;
            a_unf_exp = r && !rd;
            rd = r && (qb.size() != 0);
            wr = w && (qb.size() != 5 || rd);
            if (rd) void'(qb.pop_front());
            if (wr) qb.push_back(d);
            b_ovf_exp = w && !wr;
            b_unf_exp = r && !rd;
        end
        #1;
        chk("a_count", 32'(a_count), 32'(qa.size()));
        chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
        chk("a_full",  32'(a_full),  32'(qa.size() == 8));
        chk("a_af",    32'(a_af),    32'(qa.size() >= 7));
        chk("a_ae",    32'(a_ae),    32'(qa.size() <= 1));
        chk("a_ovf",   32'(a_ovf),   32'(a_ovf_exp));
        chk("a_unf",   32'(a_unf),   32'(a_unf_exp));
        chk("a_out",   32'(a_out),   32'(a_out_exp));
        chk("b_count", 32'(b_count), 32'(qb.size()));
        chk("b_empty", 32'(b_empty), 32'(qb.size() == 0));
        chk("b_full",  32'(b_full),  32'(qb.size() == 5));
        chk("b_af",    32'(b_af),    32'(qb.size() >= 5));
        chk("b_ae",    32'(b_ae),    32'(qb.size() == 0));
        chk("b_ovf",   32'(b_ovf),   32'(b_ovf_exp));
        chk("b_unf",   32'(b_unf),   32'(b_unf_exp));
        if (qb.size() != 0) chk("b_out_head", 32'(b_out), 32'(qb[0]));
        $display("t=%0t rst=%0b w=%0b r=%0b d=%02h | A cnt=%0d out=%02h ovf=%0b unf=%0b | B cnt=%0d out=%02h ovf=%0b unf=%0b",
                 $time, rs, w, r, d, a_count, a_out, a_ovf, a_unf, b_count, b_out, b_ovf, b_unf);
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; in_data = 8'h00;
        a_out_exp = 8'h00;
        a_ovf_exp = 1'b0; a_unf_exp = 1'b0; b_ovf_exp = 1'b0; b_unf_exp = 1'b0;

        // Reset, then fill with 0x11..0x88; also drives B past full.
        step(0, 0, 8'h00, 1);
        for (int i = 1; i <= 8; i++) step(1, 0, 8'(i * 8'h11), 0);

        // Rejected write while full, then idle to see the pulse drop.
        step(1, 0, 8'h99, 0);
        step(0, 0, 8'h00, 0);

        // Drain, then read from empty.
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Simultaneous read+write while full.
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom_range(0, 255)), 0);
        step(1, 1, 8'hA5, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 8'h00, 0);

        // Simultaneous read+write while empty: write lands, read rejected.
        step(1, 1, 8'h3C, 0);
        step(0, 1, 8'h00, 0);

        // Interleaved pairs across pointer wrap.
        step(1, 0, 8'h5A, 0);
        step(1, 0, 8'h6B, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 8'($urandom_range(0, 255)), 0);
            step(0, 1, 8'h00, 0);
        end
        for (int i = 0; i < 12; i++) step(1, 1, 8'($urandom_range(0, 255)), 0);

        // Reset mid-stream with a write pending, then prove old data is gone.
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'hC0 + i), 0);
        step(1, 0, 8'hEE, 1);
        step(0, 1, 8'h00, 0);
        step(1, 0, 8'h42, 0);
        step(0, 1, 8'h00, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
